// File: rtl/bf_out_uart_tx.sv
// UART 8N1 transmitter for the machine's output port: serializes one byte per
// request and returns a one-cycle out_ready pulse once the stop bit has left tx.
module bf_out_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DW           = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] data_in,
    input  logic          send,
    output logic          busy,
    output logic          out_ready,
    output logic          tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } stateType;

    stateType      state;
    logic [CW-1:0] baudCnt;
    logic [2:0]    bitIdx;
    logic [DW-1:0] shiftReg;

    wire bitEnd = (baudCnt == LAST_TICK);

    // tx, busy and out_ready are loaded one state ahead so each is a plain flop
    // output that already holds the value belonging to the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            out_ready <= 1'b0;
            baudCnt   <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_ready <= 1'b0;
                    if (send) begin
                        shiftReg <= data_in;
                        baudCnt  <= '0;
                        bitIdx   <= '0;
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end
                end

                START: begin
                    if (bitEnd) begin
                        baudCnt <= '0;
                        bitIdx  <= '0;
                        state   <= DATA;
                        tx      <= shiftReg[0];
                    end else begin
                        baudCnt <= baudCnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bitEnd) begin
                        baudCnt  <= '0;
                        shiftReg <= shiftReg >> 1;
                        if (bitIdx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                            // next bit is shift[1] before this edge's shift lands
                            tx     <= shiftReg[1];
                        end
                    end else begin
                        baudCnt <= baudCnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bitEnd) begin
                        baudCnt   <= '0;
                        state     <= DONE;
                        out_ready <= 1'b1;
                    end else begin
                        baudCnt <= baudCnt + 1'b1;
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    out_ready <= 1'b0;
                    busy      <= 1'b0;
                    tx        <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    out_ready <= 1'b0;
                    busy      <= 1'b0;
                    tx        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_out_uart_tx.sv
// Directed bench for bf_out_uart_tx: frame table at 4 clocks/bit, plus held-send,
// reset-mid-frame and 2 clocks/bit sequences.
module tb_bf_out_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data4, data2;
    logic       send4, send2;
    logic       busy4, ready4, tx4;
    logic       busy2, ready2, tx2;

    int errors = 0;
    int checks = 0;
    int pulses4 = 0;

    always #5 clk = ~clk;

    bf_out_uart_tx #(.CLKS_PER_BIT(4), .DW(8)) dut4 (
        .clock(clk), .reset(rst), .data_in(data4), .send(send4),
        .busy(busy4), .out_ready(ready4), .tx(tx4)
    );

    bf_out_uart_tx #(.CLKS_PER_BIT(2), .DW(8)) dut2 (
        .clock(clk), .reset(rst), .data_in(data2), .send(send2),
        .busy(busy2), .out_ready(ready2), .tx(tx2)
    );

    always @(posedge clk) if (ready4 === 1'b1) pulses4 <= pulses4 + 1;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;    // bit i = tx level in bit slot i (start, d0..d7, stop)
        logic [7:0] expByte;
        bit         disturb;
    } vecT;

    vecT vecs[5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic runFrame4(input logic [7:0] d, input logic [9:0] frame,
                             input logic [7:0] expByte, input bit disturb);
        logic [7:0] rx;
        rx = '0;
        data4 = d;
        send4 = 1'b1;
        tick;                       // accept edge E0
        send4 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            check1("tx slot", tx4, frame[k/4]);
            check1("busy in frame", busy4, 1'b1);
            check1("out_ready early", ready4, 1'b0);
            if ((k % 4) == 2 && (k / 4) >= 1 && (k / 4) <= 8) rx[k/4 - 1] = tx4;
            if (disturb) begin
                if (k == 3) begin data4 = 8'hFF; send4 = 1'b1; end
                if (k == 4) send4 = 1'b0;
                if (k == 17) data4 = 8'h00;
            end
            tick;
        end
        check1("out_ready pulse", ready4, 1'b1);
        check1("busy in done", busy4, 1'b1);
        check1("tx in done", tx4, 1'b1);
        check8("rx byte", rx, expByte);
        tick;
        check1("out_ready cleared", ready4, 1'b0);
        check1("busy cleared", busy4, 1'b0);
        check1("tx idle", tx4, 1'b1);
    endtask

    initial begin
        int startPulses;
        logic [9:0] frame00;
        logic [9:0] frame80;
        logic [7:0] rx;

        vecs[0] = '{data: 8'h2B, frame: 10'b1001010110, expByte: 8'h2B, disturb: 1'b0};
        vecs[1] = '{data: 8'h41, frame: 10'b1010000010, expByte: 8'h41, disturb: 1'b1};
        vecs[2] = '{data: 8'hFF, frame: 10'b1111111110, expByte: 8'hFF, disturb: 1'b0};
        vecs[3] = '{data: 8'h80, frame: 10'b1100000000, expByte: 8'h80, disturb: 1'b0};
        vecs[4] = '{data: 8'h0A, frame: 10'b1000010100, expByte: 8'h0A, disturb: 1'b0};
        frame00 = 10'b1000000000;
        frame80 = 10'b1100000000;

        rst = 1'b1; data4 = 8'h00; send4 = 1'b0; data2 = 8'h00; send2 = 1'b0;
        tick; tick;
        check1("reset tx", tx4, 1'b1);
        check1("reset busy", busy4, 1'b0);
        check1("reset out_ready", ready4, 1'b0);
        rst = 1'b0;

        // idle with no request
        for (int k = 0; k < 20; k++) begin
            check1("idle tx", tx4, 1'b1);
            check1("idle busy", busy4, 1'b0);
            check1("idle out_ready", ready4, 1'b0);
            tick;
        end

        foreach (vecs[i]) runFrame4(vecs[i].data, vecs[i].frame, vecs[i].expByte, vecs[i].disturb);
        checkInt("pulse count after table", pulses4, 5);

        // held send: back-to-back frames 42 cycles apart (40 frame + DONE + IDLE)
        startPulses = pulses4;
        data4 = 8'h00;
        send4 = 1'b1;
        tick;
        for (int k = 0; k < 126; k++) begin
            int m;
            m = k % 42;
            if (m < 40) begin
                check1("held tx", tx4, frame00[m/4]);
                check1("held busy", busy4, 1'b1);
                check1("held out_ready", ready4, 1'b0);
            end else if (m == 40) begin
                check1("held tx done", tx4, 1'b1);
                check1("held busy done", busy4, 1'b1);
                check1("held out_ready done", ready4, 1'b1);
            end else begin
                check1("held tx gap", tx4, 1'b1);
                check1("held busy gap", busy4, 1'b0);
                check1("held out_ready gap", ready4, 1'b0);
            end
            if (k == 124) send4 = 1'b0;
            tick;
        end
        check1("held no restart tx", tx4, 1'b1);
        check1("held no restart busy", busy4, 1'b0);
        checkInt("held pulse count", pulses4 - startPulses, 3);

        // reset mid-frame
        startPulses = pulses4;
        data4 = 8'h55;
        send4 = 1'b1;
        tick;
        send4 = 1'b0;
        for (int k = 0; k < 15; k++) tick;
        check1("pre-reset busy", busy4, 1'b1);
        rst = 1'b1;
        #1;
        check1("async reset tx", tx4, 1'b1);
        check1("async reset busy", busy4, 1'b0);
        check1("async reset out_ready", ready4, 1'b0);
        tick;
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            check1("post-reset tx", tx4, 1'b1);
            check1("post-reset out_ready", ready4, 1'b0);
            tick;
        end
        checkInt("no pulse after reset", pulses4 - startPulses, 0);
        runFrame4(8'h0A, 10'b1000010100, 8'h0A, 1'b0);
        checkInt("total pulses", pulses4, 9);

        // 2 clocks per bit
        rx = '0;
        data2 = 8'h80;
        send2 = 1'b1;
        tick;
        send2 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check1("cpb2 tx", tx2, frame80[k/2]);
            check1("cpb2 out_ready early", ready2, 1'b0);
            if ((k % 2) == 1 && (k / 2) >= 1 && (k / 2) <= 8) rx[k/2 - 1] = tx2;
            tick;
        end
        check1("cpb2 out_ready", ready2, 1'b1);
        check1("cpb2 busy done", busy2, 1'b1);
        check8("cpb2 rx byte", rx, 8'h80);
        tick;
        check1("cpb2 out_ready cleared", ready2, 1'b0);
        check1("cpb2 busy cleared", busy2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
